// File: rtl/window_3x3_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a shifting 3x3 array, one window per accepted interior pixel.
// Latency 1 (accept to out_valid); in_ready = ~out_valid | out_ready; optional WIN_COORD_EN adds out_row/out_col.
module window_3x3_gen #(
    parameter int DATA_W     = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] p1,
    output logic [DATA_W-1:0] p2,
    output logic [DATA_W-1:0] p3,
    output logic [DATA_W-1:0] p4,
    output logic [DATA_W-1:0] p5,
    output logic [DATA_W-1:0] p6,
    output logic [DATA_W-1:0] p7,
    output logic [DATA_W-1:0] p8,
    output logic [DATA_W-1:0] p9
`ifdef WIN_COORD_EN
    ,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col
`endif
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t            state;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [DATA_W-1:0] line_a [IMG_WIDTH];
    logic [DATA_W-1:0] line_b [IMG_WIDTH];
    logic [DATA_W-1:0] win [3][3];
    logic              accept;
    logic              emit;
    logic              eol;
    logic              eof;
    logic [DATA_W-1:0] top_new;
    logic [DATA_W-1:0] mid_new;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign eol      = (col == COL_LAST);
    assign eof      = eol & (row == ROW_LAST);
    // Columns 0 and 1 of a line only refill the array; windows never wrap across lines.
    assign emit     = accept & (state == RUN) & (col >= CW'(2));
    assign top_new  = line_b[col];
    assign mid_new  = line_a[col];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
        end else if (accept) begin
            if (eol) begin
                col <= '0;
                row <= eof ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            if (eof) begin
                state <= FILL;
            end else if (eol && row == RW'(1)) begin
                state <= RUN;
            end
        end
    end

    // Pixel storage is intentionally not reset; the FILL phase overwrites it before use.
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            line_b[col] <= line_a[col];
            line_a[col] <= in_data;
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= top_new;
            win[1][2] <= mid_new;
            win[2][2] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            p1 <= '0; p2 <= '0; p3 <= '0;
            p4 <= '0; p5 <= '0; p6 <= '0;
            p7 <= '0; p8 <= '0; p9 <= '0;
`ifdef WIN_COORD_EN
            out_row <= '0;
            out_col <= '0;
`endif
        end else if (emit) begin
            out_valid <= 1'b1;
            p1 <= win[0][1]; p2 <= win[0][2]; p3 <= top_new;
            p4 <= win[1][1]; p5 <= win[1][2]; p6 <= mid_new;
            p7 <= win[2][1]; p8 <= win[2][2]; p9 <= in_data;
`ifdef WIN_COORD_EN
            out_row <= 16'(row) - 16'd1;
            out_col <= 16'(col) - 16'd1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a 5x4 instance for directed ramp scenarios and an 8x6 instance for random traffic.
module tb_window_3x3_gen;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int AH = 4;
    localparam int BW = 8;
    localparam int BH = 6;
    localparam logic [71:0] FIRST_WIN = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
    localparam logic [71:0] LAST_WIN  = {8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14, 8'd17, 8'd18, 8'd19};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data;
    logic [DW-1:0] a_p [9];
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data;
    logic [DW-1:0] b_p [9];
    wire  [71:0]   a_win = {a_p[0], a_p[1], a_p[2], a_p[3], a_p[4], a_p[5], a_p[6], a_p[7], a_p[8]};
    wire  [71:0]   b_win = {b_p[0], b_p[1], b_p[2], b_p[3], b_p[4], b_p[5], b_p[6], b_p[7], b_p[8]};
`ifdef WIN_COORD_EN
    logic [15:0]   a_row, a_col, b_row, b_col;
    logic [31:0]   a_cexp_q[$];
    logic [31:0]   a_cobs_q[$];
`endif

    int          checks = 0;
    int          errors = 0;
    int          a_pix_q[$];
    int          b_pix_q[$];
    logic [71:0] a_exp_q[$];
    logic [71:0] a_obs_q[$];
    logic [71:0] b_exp_q[$];
    logic [71:0] b_obs_q[$];

    window_3x3_gen #(.DATA_W(DW), .IMG_WIDTH(AW), .IMG_HEIGHT(AH)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .p1(a_p[0]), .p2(a_p[1]), .p3(a_p[2]), .p4(a_p[3]), .p5(a_p[4]),
        .p6(a_p[5]), .p7(a_p[6]), .p8(a_p[7]), .p9(a_p[8])
`ifdef WIN_COORD_EN
        , .out_row(a_row), .out_col(a_col)
`endif
    );

    window_3x3_gen #(.DATA_W(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .p1(b_p[0]), .p2(b_p[1]), .p3(b_p[2]), .p4(b_p[3]), .p5(b_p[4]),
        .p6(b_p[5]), .p7(b_p[6]), .p8(b_p[7]), .p9(b_p[8])
`ifdef WIN_COORD_EN
        , .out_row(b_row), .out_col(b_col)
`endif
    );

    // Reference: software 3x3 extraction over a full image held in an array.
    task automatic gen_a(input int base, input bit rnd);
        logic [7:0] img [AH][AW];
        for (int r = 0; r < AH; r++)
            for (int c = 0; c < AW; c++) begin
                img[r][c] = rnd ? 8'($urandom) : 8'(base + r * AW + c);
                a_pix_q.push_back(int'(img[r][c]));
            end
        for (int r = 2; r < AH; r++)
            for (int c = 2; c < AW; c++) begin
                a_exp_q.push_back({img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                                   img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                                   img[r][c-2],   img[r][c-1],   img[r][c]});
`ifdef WIN_COORD_EN
                a_cexp_q.push_back({16'(r - 1), 16'(c - 1)});
`endif
            end
    endtask

    task automatic gen_b();
        logic [7:0] img [BH][BW];
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++) begin
                img[r][c] = 8'($urandom);
                b_pix_q.push_back(int'(img[r][c]));
            end
        for (int r = 2; r < BH; r++)
            for (int c = 2; c < BW; c++)
                b_exp_q.push_back({img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                                   img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                                   img[r][c-2],   img[r][c-1],   img[r][c]});
    endtask

    task automatic clear_q();
        a_pix_q.delete(); a_exp_q.delete(); a_obs_q.delete();
        b_pix_q.delete(); b_exp_q.delete(); b_obs_q.delete();
`ifdef WIN_COORD_EN
        a_cexp_q.delete(); a_cobs_q.delete();
`endif
    endtask

    // Streams a_pix_q into dut_a and records every window handed off downstream.
    task automatic drive_a(input int vprob, input int rprob, input int budget);
        int  cyc = 0;
        bit  acc;
        while ((a_pix_q.size() > 0 || a_out_valid) && cyc < budget) begin
            a_in_valid  = (a_pix_q.size() > 0) && ($urandom_range(99) < vprob);
            a_in_data   = (a_pix_q.size() > 0) ? 8'(a_pix_q[0]) : 8'd0;
            a_out_ready = ($urandom_range(99) < rprob);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            if (a_out_valid && a_out_ready) begin
                a_obs_q.push_back(a_win);
`ifdef WIN_COORD_EN
                a_cobs_q.push_back({a_row, a_col});
`endif
            end
            @(posedge clk); #1;
            if (acc) void'(a_pix_q.pop_front());
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL drive_a_timeout: cycles=%0d limit=%0d pixels_left=%0d", cyc, budget, a_pix_q.size());
        end
    endtask

    task automatic drive_b(input int vprob, input int rprob, input int budget);
        int  cyc = 0;
        bit  acc;
        while ((b_pix_q.size() > 0 || b_out_valid) && cyc < budget) begin
            b_in_valid  = (b_pix_q.size() > 0) && ($urandom_range(99) < vprob);
            b_in_data   = (b_pix_q.size() > 0) ? 8'(b_pix_q[0]) : 8'd0;
            b_out_ready = ($urandom_range(99) < rprob);
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            if (b_out_valid && b_out_ready) b_obs_q.push_back(b_win);
            @(posedge clk); #1;
            if (acc) void'(b_pix_q.pop_front());
            cyc++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL drive_b_timeout: cycles=%0d limit=%0d pixels_left=%0d", cyc, budget, b_pix_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hAA; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_data = 8'h55; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_out_ready = 1'b1; b_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid: got %b want 0", a_out_valid); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b want 0", b_out_valid); end
        checks++; if (a_win !== 72'd0) begin errors++; $display("FAIL reset_a_window: got %h want 0", a_win); end
        checks++; if (b_win !== 72'd0) begin errors++; $display("FAIL reset_b_window: got %h want 0", b_win); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready: got %b want 1", a_in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ramp_frame();
        clear_q();
        gen_a(0, 1'b0);
        drive_a(100, 100, 200);
        checks++;
        if (a_obs_q.size() != 6) begin errors++; $display("FAIL ramp_count: got %0d want 6", a_obs_q.size()); end
        for (int i = 0; i < a_obs_q.size() && i < a_exp_q.size(); i++) begin
            checks++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                errors++; $display("FAIL ramp_win[%0d]: got %h want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
        if (a_obs_q.size() == 6) begin
            checks++; if (a_obs_q[0] !== FIRST_WIN) begin errors++; $display("FAIL ramp_first: got %h want %h", a_obs_q[0], FIRST_WIN); end
            checks++; if (a_obs_q[5] !== LAST_WIN) begin errors++; $display("FAIL ramp_last: got %h want %h", a_obs_q[5], LAST_WIN); end
        end
`ifdef WIN_COORD_EN
        for (int i = 0; i < a_cobs_q.size() && i < a_cexp_q.size(); i++) begin
            checks++;
            if (a_cobs_q[i] !== a_cexp_q[i]) begin
                errors++; $display("FAIL coord[%0d]: got (%0d,%0d) want (%0d,%0d)", i,
                                   a_cobs_q[i][31:16], a_cobs_q[i][15:0], a_cexp_q[i][31:16], a_cexp_q[i][15:0]);
            end
        end
`endif
    endtask

    task automatic test_backpressure();
        int          cyc = 0;
        bit          acc;
        logic [71:0] held;
        clear_q();
        gen_a(0, 1'b0);
        a_out_ready = 1'b0;
        while (!a_out_valid && cyc < 100) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(a_pix_q[0]);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            @(posedge clk); #1;
            if (acc) void'(a_pix_q.pop_front());
            cyc++;
        end
        held = a_win;
        checks++; if (held !== FIRST_WIN) begin errors++; $display("FAIL hold_first: got %h want %h", held, FIRST_WIN); end
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(a_pix_q[0]);
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 1", k, a_out_valid); end
            checks++; if (a_win !== held) begin errors++; $display("FAIL hold_window[%0d]: got %h want %h", k, a_win, held); end
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, a_in_ready); end
            @(posedge clk); #1;
        end
        drive_a(100, 100, 200);
        checks++;
        if (a_obs_q.size() != 6) begin errors++; $display("FAIL hold_count: got %0d want 6", a_obs_q.size()); end
        for (int i = 0; i < a_obs_q.size() && i < a_exp_q.size(); i++) begin
            checks++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                errors++; $display("FAIL hold_win[%0d]: got %h want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        gen_a(0, 1'b0);
        gen_a(100, 1'b0);
        drive_a(100, 100, 400);
        checks++;
        if (a_obs_q.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d want 12", a_obs_q.size()); end
        for (int i = 0; i < a_obs_q.size() && i < a_exp_q.size(); i++) begin
            checks++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                errors++; $display("FAIL b2b_win[%0d]: got %h want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
        if (a_obs_q.size() > 6) begin
            checks++; if (a_obs_q[6][71:64] !== 8'd100) begin errors++; $display("FAIL b2b_f2_p1: got %0d want 100", a_obs_q[6][71:64]); end
            checks++; if (a_obs_q[6][39:32] !== 8'd106) begin errors++; $display("FAIL b2b_f2_p5: got %0d want 106", a_obs_q[6][39:32]); end
            checks++; if (a_obs_q[6][7:0] !== 8'd112) begin errors++; $display("FAIL b2b_f2_p9: got %0d want 112", a_obs_q[6][7:0]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_q();
        a_out_ready = 1'b0;
        // 13 pixels reach (2,2), so a window is pending when reset hits.
        for (int i = 0; i < 13; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = 8'(200 + i);
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_win !== 72'd0) begin errors++; $display("FAIL midrst_window: got %h want 0", a_win); end
        @(posedge clk); #1;
        gen_a(0, 1'b0);
        drive_a(100, 100, 200);
        checks++;
        if (a_obs_q.size() != 6) begin errors++; $display("FAIL midrst_count: got %0d want 6", a_obs_q.size()); end
        for (int i = 0; i < a_obs_q.size() && i < a_exp_q.size(); i++) begin
            checks++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                errors++; $display("FAIL midrst_win[%0d]: got %h want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
    endtask

    task automatic test_random_gaps();
        clear_q();
        gen_b();
        gen_b();
        drive_b(50, 50, 3000);
        checks++;
        if (b_obs_q.size() != 48) begin errors++; $display("FAIL rand_b_count: got %0d want 48", b_obs_q.size()); end
        for (int i = 0; i < b_obs_q.size() && i < b_exp_q.size(); i++) begin
            checks++;
            if (b_obs_q[i] !== b_exp_q[i]) begin
                errors++; $display("FAIL rand_b_win[%0d]: got %h want %h", i, b_obs_q[i], b_exp_q[i]);
            end
        end
        gen_a(0, 1'b1);
        gen_a(0, 1'b1);
        drive_a(50, 50, 1500);
        checks++;
        if (a_obs_q.size() != 12) begin errors++; $display("FAIL rand_a_count: got %0d want 12", a_obs_q.size()); end
        for (int i = 0; i < a_obs_q.size() && i < a_exp_q.size(); i++) begin
            checks++;
            if (a_obs_q[i] !== a_exp_q[i]) begin
                errors++; $display("FAIL rand_a_win[%0d]: got %h want %h", i, a_obs_q[i], a_exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_ramp_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: time=%0t limit=1000000", $time);
        $fatal(1);
    end

endmodule
